// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants and FSM state type for the Keccak unpadder.
package keccak_pkg;
  localparam int LANE_W = 64;
  localparam int LANES = 9;
  localparam int RATE_W = LANE_W * LANES;
  localparam logic [7:0] PAD_FIRST = 8'h01;
  localparam int PAD_LAST_BIT = 7;
  typedef enum logic [1:0] {IDLE, SCAN, STREAM} state_t;
endpackage

// File: rtl/keccak_lane_scan.sv
// keccak_lane_scan: finds the highest nonzero byte of a lane and checks it is the pad marker.
module keccak_lane_scan
  import keccak_pkg::*;
(
  input  logic [LANE_W-1:0] lane,
  input  logic              mask_top,
  output logic              found,
  output logic [2:0]        byte_idx,
  output logic              marker_ok
);
  logic [LANE_W-1:0] m;
  always_comb begin
    m = lane;
    m[LANE_W-8+PAD_LAST_BIT] = lane[LANE_W-8+PAD_LAST_BIT] & ~mask_top;
    found = 1'b0;
    byte_idx = 3'd0;
    for (int b = 0; b < 8; b++)
      if (|m[8*b +: 8]) begin
        found = 1'b1;
        byte_idx = 3'(b);
      end
    marker_ok = m[8*byte_idx +: 8] == PAD_FIRST;
  end
endmodule

// File: rtl/keccak_unpadder.sv
// keccak_unpadder: streams rate blocks out lane by lane, validating pad10*1 on the final block.
module keccak_unpadder #(
  parameter int LANES = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [64*LANES-1:0]   blk_in,
  input  logic                  blk_valid,
  input  logic                  blk_last,
  output logic                  blk_ready,
  output logic [63:0]           word_out,
  output logic [3:0]            word_bytes,
  output logic                  word_last,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  pad_err
);
  import keccak_pkg::*;
  localparam logic [3:0] LAST_LANE = 4'(LANES - 1);
  state_t state, state_n;
  logic [64*LANES-1:0] blk_r, blk_n;
  logic [3:0] idx, idx_n, nwords, nwords_n, nlast, nlast_n;
  logic fin, fin_n, err_n, up, found, marker_ok, at_end;
  logic [2:0] byte_idx;
  logic [6:0] l;
  logic [63:0] lane, keep;
  assign lane = blk_r[64*(LANES-1-int'(idx)) +: 64];
  keccak_lane_scan u_scan (
    .lane(lane),
    .mask_top(idx == LAST_LANE),
    .found(found),
    .byte_idx(byte_idx),
    .marker_ok(marker_ok)
  );
  // message length = 8*lane + byte of the marker
  assign l = {idx, byte_idx};
  assign at_end = idx == nwords - 4'd1;
  assign blk_ready = up && state == IDLE;
  assign word_valid = state == STREAM;
  assign word_last = word_valid && fin && at_end;
  assign word_bytes = word_valid ? (at_end ? nlast : 4'd8) : 4'd0;
  always_comb
    for (int b = 0; b < 8; b++)
      keep[8*b +: 8] = {8{4'(b) < word_bytes}};
  assign word_out = lane & keep;
  always_comb begin
    state_n = state;
    blk_n = blk_r;
    idx_n = idx;
    nwords_n = nwords;
    nlast_n = nlast;
    fin_n = fin;
    err_n = 1'b0;
    case (state)
      IDLE:
        if (blk_valid && blk_ready) begin
          blk_n = blk_in;
          fin_n = blk_last;
          nwords_n = 4'(LANES);
          nlast_n = 4'd8;
          idx_n = blk_last ? LAST_LANE : 4'd0;
          state_n = blk_last ? SCAN : STREAM;
        end
      SCAN:
        if ((idx == LAST_LANE && !lane[56+PAD_LAST_BIT]) || (found && !marker_ok) || (!found && idx == 4'd0)) begin
          err_n = 1'b1;
          state_n = IDLE;
        end else if (found) begin
          nwords_n = l == 7'd0 ? 4'd1 : 4'((l + 7'd7) >> 3);
          nlast_n = l[2:0] != 3'd0 ? {1'b0, l[2:0]} : (l == 7'd0 ? 4'd0 : 4'd8);
          idx_n = 4'd0;
          state_n = STREAM;
        end else
          idx_n = idx - 4'd1;
      STREAM:
        if (word_ready) begin
          idx_n = idx + 4'd1;
          state_n = at_end ? IDLE : STREAM;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      blk_r <= '0;
      idx <= '0;
      nwords <= '0;
      nlast <= '0;
      fin <= 1'b0;
      pad_err <= 1'b0;
      up <= 1'b0;
    end else begin
      state <= state_n;
      blk_r <= blk_n;
      idx <= idx_n;
      nwords <= nwords_n;
      nlast <= nlast_n;
      fin <= fin_n;
      pad_err <= err_n;
      up <= 1'b1;
    end
endmodule

// File: tb/tb_keccak_unpadder.sv
// tb_keccak_unpadder: randomized and directed checks against a byte-level unpadding model.
module tb_keccak_unpadder;
  typedef struct {logic [63:0] d; logic [3:0] n; logic l;} wd_t;
  logic clk = 0, rst_n = 0;
  logic [575:0] blk_in = '0;
  logic blk_valid = 0, blk_last = 0, blk_ready;
  logic [63:0] word_out;
  logic [3:0] word_bytes;
  logic word_last, word_valid, word_ready = 1, pad_err;
  int checks = 0, errors = 0, pe_exp = 0, pe_seen = 0, hs_cnt = 0, mode = 0, rcyc = 0;
  wd_t exp_q[$];
  logic [7:0] mb [72];
  logic stall = 0, prev_pe = 0;
  logic [68:0] prev_w = '0;

  always #5 clk = ~clk;

  keccak_unpadder dut (
    .clk(clk), .rst_n(rst_n), .blk_in(blk_in), .blk_valid(blk_valid), .blk_last(blk_last),
    .blk_ready(blk_ready), .word_out(word_out), .word_bytes(word_bytes), .word_last(word_last),
    .word_valid(word_valid), .word_ready(word_ready), .pad_err(pad_err)
  );

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    rcyc++;
    word_ready = mode == 0 ? 1'b1 : mode == 1 ? (rcyc % 4 == 0 || rcyc % 4 == 3) : 1'($urandom % 2);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall <= 1'b0;
      prev_pe <= 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", word_valid, 1);
        chk("stall_hold", {word_out, word_bytes, word_last}, prev_w);
      end
      if (pad_err) begin
        chk("pad_err_single", prev_pe, 0);
        pe_seen++;
      end
      if (word_valid) begin
        chk("word_expected", 80'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("word_out", word_out, exp_q[0].d);
          chk("word_bytes", word_bytes, exp_q[0].n);
          chk("word_last", word_last, exp_q[0].l);
          if (word_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
      stall <= word_valid && !word_ready;
      prev_pe <= pad_err;
      prev_w <= {word_out, word_bytes, word_last};
    end
  end

  task automatic model(input bit last);
    wd_t w;
    int l, cnt, nb;
    logic [7:0] v, lv;
    if (!last) begin
      for (int k = 0; k < 9; k++) begin
        for (int b = 0; b < 8; b++) w.d[8*b +: 8] = mb[8*k + b];
        w.n = 4'd8;
        w.l = 1'b0;
        exp_q.push_back(w);
      end
      return;
    end
    if (!mb[71][7]) begin
      pe_exp++;
      return;
    end
    l = -1;
    lv = 8'h00;
    for (int n = 71; n >= 0; n--) begin
      v = n == 71 ? {1'b0, mb[71][6:0]} : mb[n];
      if (v != 8'h00) begin
        l = n;
        lv = v;
        break;
      end
    end
    if (l < 0 || lv != 8'h01) begin
      pe_exp++;
      return;
    end
    cnt = l == 0 ? 1 : (l + 7) / 8;
    for (int i = 0; i < cnt; i++) begin
      nb = i == cnt - 1 ? l - 8 * (cnt - 1) : 8;
      w.d = '0;
      for (int b = 0; b < nb; b++) w.d[8*b +: 8] = mb[8*i + b];
      w.n = 4'(nb);
      w.l = i == cnt - 1;
      exp_q.push_back(w);
    end
  endtask

  task automatic gen_valid(input int l);
    for (int n = 0; n < 72; n++) mb[n] = n < l ? 8'($urandom) : 8'h00;
    mb[l] = 8'h01;
    mb[71] = mb[71] | 8'h80;
  endtask

  task automatic rand_block();
    for (int n = 0; n < 72; n++) mb[n] = 8'($urandom);
  endtask

  task automatic send(input bit last);
    int t = 0;
    while (!blk_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("blk_ready_wait", blk_ready, 1);
    for (int n = 0; n < 72; n++) blk_in[(8 - n / 8) * 64 + (n % 8) * 8 +: 8] = mb[n];
    blk_last = last;
    blk_valid = 1;
    @(posedge clk); #1;
    blk_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !blk_ready) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_done", 80'(t < 400), 1);
    @(posedge clk); #1;
    chk("pad_err_count", pe_seen, pe_exp);
  endtask

  initial begin
    int c, h, p, t, k, l;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_blk_ready", blk_ready, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_word_out", word_out, 0);
    chk("rst_word_bytes", word_bytes, 0);
    chk("rst_word_last", word_last, 0);
    chk("rst_pad_err", pad_err, 0);
    rst_n = 1;
    #1;
    chk("ready_before_clk", blk_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_clk", blk_ready, 1);

    for (int n = 0; n < 72; n++) mb[n] = 8'((n / 8 + 1) * 17);
    model(0);
    chk("model_nf_lane8", exp_q[8].d, 64'h9999999999999999);
    send(0);
    chk("nf_word0_valid", word_valid, 1);
    chk("nf_word0", word_out, 64'h1111111111111111);
    drain();

    gen_valid(20);
    model(1);
    chk("model_l20_words", exp_q.size(), 3);
    chk("model_l20_bytes", exp_q[2].n, 4);
    chk("model_l20_last", exp_q[2].l, 1);
    send(1);
    c = 0;
    while (!word_valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("l20_scan_cycles", c, 7);
    drain();

    gen_valid(71);
    model(1);
    chk("model_l71_words", exp_q.size(), 9);
    chk("model_l71_bytes", exp_q[8].n, 7);
    send(1);
    drain();

    gen_valid(0);
    model(1);
    chk("model_l0_words", exp_q.size(), 1);
    chk("model_l0_bytes", exp_q[0].n, 0);
    chk("model_l0_data", exp_q[0].d, 0);
    send(1);
    drain();

    gen_valid(30);
    mb[71] = 8'h00;
    p = pe_exp;
    model(1);
    chk("model_err71", pe_exp, p + 1);
    send(1);
    drain();
    chk("err71_ready", blk_ready, 1);

    gen_valid(45);
    mb[45] = 8'h03;
    p = pe_exp;
    model(1);
    chk("model_err03", pe_exp, p + 1);
    send(1);
    drain();
    chk("err03_ready", blk_ready, 1);

    mode = 1;
    gen_valid(40);
    h = hs_cnt;
    model(1);
    send(1);
    drain();
    chk("l40_words", hs_cnt - h, 5);
    mode = 0;

    rand_block();
    model(0);
    h = hs_cnt;
    send(0);
    t = 0;
    while (hs_cnt - h < 4 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_reset_reach", 80'(t < 100), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_out", word_out, 0);
    chk("mid_rst_bytes", word_bytes, 0);
    chk("mid_rst_last", word_last, 0);
    chk("mid_rst_ready", blk_ready, 0);
    chk("mid_rst_pad_err", pad_err, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    rand_block();
    model(0);
    send(0);
    drain();

    mode = 2;
    repeat (40) begin
      k = $urandom % 4;
      l = $urandom % 72;
      if (k == 0) begin
        rand_block();
        model(0);
        send(0);
      end else begin
        gen_valid(l);
        if (k == 3) begin
          c = $urandom % 3;
          if (c == 0) mb[71][7] = 1'b0;
          else if (c == 1) mb[l] = l == 71 ? 8'h83 : 8'h03;
          else begin
            for (int n = 0; n < 72; n++) mb[n] = 8'h00;
            mb[71] = 8'h80;
          end
        end
        model(1);
        send(1);
      end
      drain();
    end
    mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keccak_unpadder.md
# keccak_unpadder

Receive-side counterpart of the Keccak padding stage: accepts 576-bit rate blocks (9 × 64-bit lanes) and streams the message back out one lane per word. For the final block it locates and validates the pad10*1 pattern, then reports the true byte count of the last word. It sits at the exit of a block buffer and feeds a word-wide consumer; it is used for loopback checking of the padder and for any path that recovers message data from padded blocks.

## Interface

Parameters:
- LANES, 9, lanes per block; block width = 64·LANES (576 default).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- blk_in  in  64·LANES  padded block; lane 0 = blk_in[575:512], lane 8 = blk_in[63:0]
- blk_valid  in  1  blk_in/blk_last valid
- blk_last  in  1  block is the final (padded) block of the message
- blk_ready  out  1  block accepted when blk_valid && blk_ready
- word_out  out  64  message lane; byte b = word_out[8b+7:8b]
- word_bytes  out  4  valid bytes in word_out, 0..8 (low bytes valid)
- word_last  out  1  last word of message
- word_valid  out  1  word_out/word_bytes/word_last valid
- word_ready  in  1  consumer accepts when word_valid && word_ready
- pad_err  out  1  one-cycle pulse: final block has malformed padding

## Operation

- Byte numbering in a block: n = 8·lane + b, 0..71. Pad rule: byte at message length L is 0x01, bytes L+1..70 are 0x00, byte 71 has bit 7 set; L = 71 gives byte 71 = 0x81.
- States: IDLE, SCAN, STREAM.
- IDLE: blk_ready = 1. On accept, register block and blk_last; lane counter cleared. blk_last = 0 → STREAM with word count 9, all words word_bytes = 8, word_last = 0. blk_last = 1 → SCAN.
- SCAN: one lane per cycle, lane 8 down to 0. Byte 71 examined with bit 7 masked; if byte 71 bit 7 is 0 → error. In each lane, find highest nonzero byte; first found ends scan. Found byte must equal 0x01 (after mask) → L = 8·lane + b, else error. No nonzero byte through lane 0 → error.
- Error: pad_err pulses one cycle, block discarded, no words emitted, → IDLE.
- Valid L: words emitted = ceil(L/8), lanes 0..ceil(L/8)−1; last word word_bytes = L − 8·(words−1); word_last on final word. L = 0: one word, word_bytes = 0, word_out = 0, word_last = 1.
- STREAM: word_out = registered lane[idx]; advance idx on handshake; after final word handshake → IDLE.
- Bytes above word_bytes in the last word are forced to 0.
- L width 7 bits, word count 4 bits; no wrap beyond LANES.

## Timing

- Reset: blk_ready = 0, word_valid = 0, word_out = 0, word_bytes = 0, word_last = 0, pad_err = 0, state IDLE; blk_ready rises the first clk after rst_n deasserts.
- Non-final block: word 0 valid the cycle after acceptance; one word per cycle at full throughput; block accepted every 10 cycles minimum.
- Final block: scan takes 9 − lane_of_marker cycles (1..9); word 0 valid the cycle after scan ends; pad_err asserted the cycle after the failing lane check.
- blk_ready = 0 outside IDLE; no overlap of consecutive blocks.
- word_valid held, outputs stable, while word_ready = 0; word_valid never deasserts without handshake.
- rst_n asserted mid-SCAN or mid-STREAM: all state and outputs cleared immediately; partial block discarded.

## Structure

- Shared package keccak_pkg: LANE_W = 64, LANES = 9, RATE_W = 576, PAD_FIRST = 8'h01, PAD_LAST_BIT = 7, state enum.
- Sub-module keccak_lane_scan (combinational): lane in, mask_top flag → found, byte index (3 bits), marker_ok.
- Top: FSM, block register, lane index counter, L computation, output registers.

## Test plan

- Non-final block, lanes = 0x1111…·k → 9 words, word_bytes = 8, word_last = 0, values in lane order.
- Final block, L = 20 (byte 20 = 0x01, byte 71 = 0x80) → 3 words, word_bytes 8,8,4, word_last on 3rd, byte 4..7 of 3rd zero; scan 7 cycles.
- Final block, L = 71 (byte 71 = 0x81) → 9 words, last word_bytes = 7; L = 0 (byte 0 = 0x01) → one word, word_bytes = 0, word_last = 1.
- Byte 71 = 0x00, or marker byte = 0x03 → pad_err single pulse, no word_valid, blk_ready back to 1.
- word_ready toggled 1-0-0-1 pattern during L = 40 stream → outputs stable while stalled, exactly 5 words, no loss or duplicate.
- rst_n low at word 4 of a non-final stream → all outputs 0 same cycle; after release, new block streams from lane 0.
